msd_fe_adc_emulator: RTL and testbench



---
 rtl/msd_fe_adc_emulator_pkg.sv | 39 +++
 rtl/msd_fe_adc_emulator_if.sv | 32 +++
 rtl/msd_fe_adc_emulator_lfsr.sv | 30 +++
 rtl/msd_fe_adc_emulator.sv | 149 ++++++++++++++
 tb/tb_msd_fe_adc_emulator.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/msd_fe_adc_emulator_pkg.sv
// -----------------------------------------------------------------------------
// Shared declarations for the microstrip front-end / ADC emulator.
//
// FOOTpackage : readout-wide sizing constants (ADC width, channels per chain,
//               number of serial ADC lines).
// pkgMsdEmu   : emulator FSM state encoding, field widths of the traceable
//               sample word and the noise LFSR constants.
// -----------------------------------------------------------------------------
package FOOTpackage;
  localparam int cadc_data_width = 16;
  localparam int cfe_channels    = 64;
  localparam int ctotal_adcs     = 10;
endpackage : FOOTpackage

package pkgMsdEmu;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    SHIFT = 2'd2
  } emu_state_t;

  // Sample word layout, MSB to LSB: {adc index, event, channel}
  localparam int ADC_FIELD_W  = 4;
  localparam int EVT_FIELD_W  = 4;
  localparam int CHAN_FIELD_W = 8;
  localparam int WORD_W       = ADC_FIELD_W + EVT_FIELD_W + CHAN_FIELD_W;

  // Galois LFSR used by the optional noise feature
  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  function automatic logic [WORD_W-1:0] pack_word(
    input logic [ADC_FIELD_W-1:0]  adc,
    input logic [EVT_FIELD_W-1:0]  evt,
    input logic [CHAN_FIELD_W-1:0] chan
  );
    return {adc, evt, chan};
  endfunction
endpackage : pkgMsdEmu

// File: rtl/msd_fe_adc_emulator_if.sv
// -----------------------------------------------------------------------------
// FE/ADC strobe bus between the readout sequencer and the emulator.
//
//   iFE_HOLD    hold, high for one event readout        (sequencer -> emulator)
//   iFE_CLK     FE shift clock, rising edge = next chan (sequencer -> emulator)
//   iADC_CS_N   ADC chip select, active low             (sequencer -> emulator)
//   iADC_SCLK   ADC serial clock                        (sequencer -> emulator)
//   oADC_SDATA  one MSB-first serial line per ADC       (emulator -> sequencer)
//
// master = sequencer side, slave = emulator side.
// -----------------------------------------------------------------------------
interface msd_fe_adc_emulator_if
  import FOOTpackage::*;
#(
  parameter int TOTAL_ADCS = ctotal_adcs
);
  logic                  iFE_HOLD;
  logic                  iFE_CLK;
  logic                  iADC_CS_N;
  logic                  iADC_SCLK;
  logic [TOTAL_ADCS-1:0] oADC_SDATA;

  modport master (
    output iFE_HOLD, iFE_CLK, iADC_CS_N, iADC_SCLK,
    input  oADC_SDATA
  );

  modport slave (
    input  iFE_HOLD, iFE_CLK, iADC_CS_N, iADC_SCLK,
    output oADC_SDATA
  );
endinterface : msd_fe_adc_emulator_if

// File: rtl/msd_fe_adc_emulator_lfsr.sv
// -----------------------------------------------------------------------------
// msd_emu_lfsr: 16-bit Galois LFSR (polynomial 0xB400, seed 0xACE1) that
// steps once per i_adv pulse. Only its low three bits are exported; they are
// the noise mixed into the channel field of loaded words.
//
//   i_clk    system clock
//   i_rst    async active-high reset, restores the seed
//   i_adv    advance one step
//   o_noise  current low three bits of the LFSR state
// -----------------------------------------------------------------------------
module msd_emu_lfsr
  import pkgMsdEmu::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_adv,
  output logic [2:0] o_noise
);
  logic [15:0] r_lfsr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lfsr <= LFSR_SEED;
    end else if (i_adv) begin
      r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_POLY : 16'h0000);
    end
  end

  assign o_noise = r_lfsr[2:0];
endmodule : msd_emu_lfsr

// File: rtl/msd_fe_adc_emulator.sv
// -----------------------------------------------------------------------------
// msd_fe_adc_emulator: responder-side emulation of the microstrip FE daisy
// chain and its serial ADCs. Every loaded word is {adc, evt[3:0], chan[7:0]}
// resized at the MSB end to ADC_DATA_WIDTH, so every sample is traceable.
//
// Ports
//   iCLK       fast system clock
//   iRST       async active-high reset
//   fe_if      strobe bus (slave modport): hold, FE clock, CS_N, SCLK in;
//              one serial data line per ADC out
//   oEVT_CNT   number of hold rising edges seen (wraps at 16 bits)
//   oOVERRUN   sticky: FE clock edge received while already at last channel
//
// Optional build macro MSD_EMU_NOISE_EN: XORs the low 3 bits of a per-load
// LFSR into chan[2:0] of every loaded word.
// -----------------------------------------------------------------------------
module msd_fe_adc_emulator
  import FOOTpackage::*;
  import pkgMsdEmu::*;
#(
  parameter int ADC_DATA_WIDTH = cadc_data_width,
  parameter int FE_CHANNELS    = cfe_channels,
  parameter int TOTAL_ADCS     = ctotal_adcs
)(
  input  logic                  iCLK,
  input  logic                  iRST,
  msd_fe_adc_emulator_if.slave  fe_if,
  output logic [15:0]           oEVT_CNT,
  output logic                  oOVERRUN
);
  localparam logic [CHAN_FIELD_W-1:0] LAST_CH = CHAN_FIELD_W'(FE_CHANNELS - 1);

  emu_state_t                r_state;
  logic [CHAN_FIELD_W-1:0]   r_chan;
  logic [15:0]               r_evt;
  logic                      r_ovr;
  logic [ADC_DATA_WIDTH-1:0] r_sreg [TOTAL_ADCS];

  // Strobe synchronisers: _p0 is the first register, _p1 the edge reference
  logic r_hold_p0, r_hold_p1;
  logic r_fe_p0,   r_fe_p1;
  logic r_cs_p0,   r_cs_p1;
  logic r_sclk_p0, r_sclk_p1;

  logic                      w_hold_rise, w_hold_fall, w_fe_rise;
  logic                      w_cs_fall, w_cs_rise, w_sclk_fall;
  logic                      w_load;
  logic [CHAN_FIELD_W-1:0]   w_chan_ld;
  logic [ADC_DATA_WIDTH-1:0] w_ld [TOTAL_ADCS];

  // ---- stage p0/p1: register strobes twice ----
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_hold_p0 <= 1'b0;  r_hold_p1 <= 1'b0;
      r_fe_p0   <= 1'b0;  r_fe_p1   <= 1'b0;
      r_cs_p0   <= 1'b1;  r_cs_p1   <= 1'b1;
      r_sclk_p0 <= 1'b0;  r_sclk_p1 <= 1'b0;
    end else begin
      r_hold_p0 <= fe_if.iFE_HOLD;   r_hold_p1 <= r_hold_p0;
      r_fe_p0   <= fe_if.iFE_CLK;    r_fe_p1   <= r_fe_p0;
      r_cs_p0   <= fe_if.iADC_CS_N;  r_cs_p1   <= r_cs_p0;
      r_sclk_p0 <= fe_if.iADC_SCLK;  r_sclk_p1 <= r_sclk_p0;
    end
  end

  assign w_hold_rise = r_hold_p0 & ~r_hold_p1;
  assign w_hold_fall = ~r_hold_p0 & r_hold_p1;
  assign w_fe_rise   = r_fe_p0 & ~r_fe_p1;
  assign w_cs_fall   = ~r_cs_p0 & r_cs_p1;
  assign w_cs_rise   = r_cs_p0 & ~r_cs_p1;
  assign w_sclk_fall = ~r_sclk_p0 & r_sclk_p1;

  // Hold falling in the same cycle as CS falling suppresses the load
  assign w_load = (r_state == HOLD) && w_cs_fall && !w_hold_fall;

`ifdef MSD_EMU_NOISE_EN
  logic [2:0] w_noise;

  msd_emu_lfsr u_lfsr (
    .i_clk   (iCLK),
    .i_rst   (iRST),
    .i_adv   (w_load),
    .o_noise (w_noise)
  );

  assign w_chan_ld = r_chan ^ {{(CHAN_FIELD_W-3){1'b0}}, w_noise};
`else
  assign w_chan_ld = r_chan;
`endif

  always_comb begin
    for (int i = 0; i < TOTAL_ADCS; i++) begin
      w_ld[i] = ADC_DATA_WIDTH'(pack_word(ADC_FIELD_W'(i), r_evt[EVT_FIELD_W-1:0], w_chan_ld));
    end
  end

  // ---- stage p2: FSM, counters and shift registers ----
  // r_chan is read before its own update, so a load coinciding with an FE
  // clock edge captures the pre-increment channel.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state <= IDLE;
      r_chan  <= '0;
      r_evt   <= '0;
      r_ovr   <= 1'b0;
      for (int i = 0; i < TOTAL_ADCS; i++) r_sreg[i] <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_hold_rise) begin
            r_chan  <= '0;
            r_evt   <= r_evt + 16'd1;
            r_state <= HOLD;
          end
        end
        HOLD, SHIFT: begin
          if (w_fe_rise) begin
            if (r_chan == LAST_CH) r_ovr  <= 1'b1;
            else                   r_chan <= r_chan + 1'b1;
          end
          if (r_state == HOLD) begin
            if (w_hold_fall) begin
              r_state <= IDLE;
            end else if (w_load) begin
              for (int i = 0; i < TOTAL_ADCS; i++) r_sreg[i] <= w_ld[i];
              r_state <= SHIFT;
            end
          end else begin
            if (w_cs_rise) begin
              r_state <= r_hold_p0 ? HOLD : IDLE;
            end else if (w_sclk_fall) begin
              for (int i = 0; i < TOTAL_ADCS; i++)
                r_sreg[i] <= {r_sreg[i][ADC_DATA_WIDTH-2:0], 1'b0};
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  genvar g;
  for (g = 0; g < TOTAL_ADCS; g++) begin : g_sdata
    assign fe_if.oADC_SDATA[g] = r_sreg[g][ADC_DATA_WIDTH-1];
  end

  assign oEVT_CNT = r_evt;
  assign oOVERRUN = r_ovr;
endmodule : msd_fe_adc_emulator

// File: tb/tb_msd_fe_adc_emulator.sv
// -----------------------------------------------------------------------------
// Directed bench for msd_fe_adc_emulator (default build, 16-bit words,
// 64 channels, 10 ADCs). Inputs change 1 ns after a rising clock edge and
// outputs are read at the same point, away from the active edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_msd_fe_adc_emulator;
  localparam int NADC = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] evt_cnt;
  logic        overrun;
  logic [15:0] words [NADC];
  logic        idle_bad;
  int          n_pass  = 0;
  int          n_fail  = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  msd_fe_adc_emulator_if #(.TOTAL_ADCS(NADC)) ifc ();

  msd_fe_adc_emulator #(
    .ADC_DATA_WIDTH (16),
    .FE_CHANNELS    (64),
    .TOTAL_ADCS     (NADC)
  ) dut (
    .iCLK     (clk),
    .iRST     (rst),
    .fe_if    (ifc.slave),
    .oEVT_CNT (evt_cnt),
    .oOVERRUN (overrun)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // 16 SCLK pulses, 4 cycles per level; bits sampled while SCLK is high
  task automatic read_words();
    for (int b = 15; b >= 0; b--) begin
      ifc.iADC_SCLK = 1'b1;
      step(4);
      for (int a = 0; a < NADC; a++) words[a][b] = ifc.oADC_SDATA[a];
      ifc.iADC_SCLK = 1'b0;
      step(4);
    end
  endtask

  task automatic fe_pulses(input int n);
    for (int k = 0; k < n; k++) begin
      ifc.iFE_CLK = 1'b1;
      step(3);
      ifc.iFE_CLK = 1'b0;
      step(3);
    end
  endtask

  initial begin
    ifc.iFE_HOLD  = 1'b0;
    ifc.iFE_CLK   = 1'b0;
    ifc.iADC_CS_N = 1'b1;
    ifc.iADC_SCLK = 1'b0;
    idle_bad      = 1'b0;

    // Reset with strobes idle
    step(3);
    rst = 1'b0;
    step(1);
    chk("reset_sdata",   32'(ifc.oADC_SDATA), 32'h0);
    chk("reset_evt",     32'(evt_cnt),        32'h0);
    chk("reset_overrun", 32'(overrun),        32'h0);

    // 1000 cycles of SCLK/CS activity with hold low
    for (int c = 0; c < 1000; c++) begin
      if (c % 2 == 0) ifc.iADC_SCLK = ~ifc.iADC_SCLK;
      if (c % 16 == 0) ifc.iADC_CS_N = ~ifc.iADC_CS_N;
      step(1);
      if (ifc.oADC_SDATA != '0) idle_bad = 1'b1;
    end
    ifc.iADC_SCLK = 1'b0;
    ifc.iADC_CS_N = 1'b1;
    step(4);
    chk("idle_sclk_sdata", 32'(idle_bad), 32'h0);
    chk("idle_evt",        32'(evt_cnt),  32'h0);

    // Single event: evt 1, chan 0
    ifc.iFE_HOLD = 1'b1;
    step(3);
    chk("evt_after_hold", 32'(evt_cnt), 32'h1);
    ifc.iADC_CS_N = 1'b0;
    step(4);
    read_words();
    chk("ev1_adc3", 32'(words[3]), 32'h3100);
    chk("ev1_adc0", 32'(words[0]), 32'h0100);
    chk("ev1_adc9", 32'(words[9]), 32'h9100);
    ifc.iADC_CS_N = 1'b1;
    step(4);

    // Channel walk: 5 FE clocks -> chan 5
    fe_pulses(5);
    ifc.iADC_CS_N = 1'b0;
    step(4);
    read_words();
    chk("walk_adc0", 32'(words[0]), 32'h0105);
    chk("walk_adc7", 32'(words[7]), 32'h7105);
    ifc.iADC_SCLK = 1'b1;
    step(4);
    ifc.iADC_SCLK = 1'b0;
    step(4);
    chk("walk_17th_fall", 32'(ifc.oADC_SDATA), 32'h0);
    ifc.iADC_CS_N = 1'b1;
    step(4);

    // CS falling together with FE_CLK rising: old channel loaded
    ifc.iFE_CLK   = 1'b1;
    ifc.iADC_CS_N = 1'b0;
    step(4);
    ifc.iFE_CLK = 1'b0;
    read_words();
    chk("coll_cs_fe_adc0", 32'(words[0]), 32'h0105);
    ifc.iADC_CS_N = 1'b1;
    step(4);
    ifc.iADC_CS_N = 1'b0;
    step(4);
    read_words();
    chk("coll_next_adc2", 32'(words[2]), 32'h2106);
    ifc.iADC_CS_N = 1'b1;
    step(4);

    // Hold falling together with CS falling: no load, back to IDLE
    ifc.iFE_HOLD  = 1'b0;
    ifc.iADC_CS_N = 1'b0;
    step(4);
    chk("coll_hold_cs_noload", 32'(ifc.oADC_SDATA), 32'h0);
    ifc.iADC_CS_N = 1'b1;
    step(4);
    ifc.iADC_CS_N = 1'b0;
    step(4);
    chk("idle_cs_ignored", 32'(ifc.oADC_SDATA), 32'h0);
    ifc.iADC_CS_N = 1'b1;
    step(4);

    // Overrun: evt 2, 64 FE clocks
    ifc.iFE_HOLD = 1'b1;
    step(3);
    chk("evt2", 32'(evt_cnt), 32'h2);
    fe_pulses(63);
    chk("no_overrun_at_63", 32'(overrun), 32'h0);
    fe_pulses(1);
    chk("overrun_set", 32'(overrun), 32'h1);
    ifc.iADC_CS_N = 1'b0;
    step(1);
    chk("cs_latency_1cyc", 32'(ifc.oADC_SDATA), 32'h0);
    step(1);
    chk("cs_latency_2cyc", 32'(ifc.oADC_SDATA), 32'h300);
    step(2);
    read_words();
    chk("ovr_adc0", 32'(words[0]), 32'h023F);
    chk("ovr_adc5", 32'(words[5]), 32'h523F);
    ifc.iADC_CS_N = 1'b1;
    step(4);
    ifc.iFE_HOLD = 1'b0;
    step(4);
    ifc.iFE_HOLD = 1'b1;
    step(3);
    chk("evt3", 32'(evt_cnt), 32'h3);
    chk("overrun_sticky", 32'(overrun), 32'h1);

    // Reset mid-shift after 7 bits: word bit 8 (evt[0]=1) is on every line
    ifc.iADC_CS_N = 1'b0;
    step(4);
    for (int b = 0; b < 7; b++) begin
      ifc.iADC_SCLK = 1'b1;
      step(4);
      ifc.iADC_SCLK = 1'b0;
      step(4);
    end
    chk("mid_shift_bit8", 32'(ifc.oADC_SDATA), 32'h3FF);
    rst = 1'b1;
    #1;
    chk("async_rst_sdata",   32'(ifc.oADC_SDATA), 32'h0);
    chk("async_rst_evt",     32'(evt_cnt),        32'h0);
    chk("async_rst_overrun", 32'(overrun),        32'h0);
    ifc.iFE_HOLD  = 1'b0;
    ifc.iADC_CS_N = 1'b1;
    step(3);
    rst = 1'b0;
    step(3);
    ifc.iFE_HOLD = 1'b1;
    step(3);
    chk("post_rst_evt", 32'(evt_cnt), 32'h1);
    ifc.iADC_CS_N = 1'b0;
    step(4);
    read_words();
    chk("post_rst_adc3", 32'(words[3]), 32'h3100);
    ifc.iADC_CS_N = 1'b1;
    ifc.iFE_HOLD  = 1'b0;
    step(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule : tb_msd_fe_adc_emulator
